// File: rtl/libstf_pkg.sv
// Shared types and register map for the stream buffer-descriptor queues.
package libstf;
  localparam int VADDR_W = 64;
  localparam int SIZE_W  = 32;

  typedef logic [VADDR_W-1:0] vaddress_t;
  typedef logic [SIZE_W-1:0]  alloc_size_t;

  typedef struct packed {
    vaddress_t   vaddr;
    alloc_size_t size;
  } buffer_t;

  localparam int MEM_CFG_REGS_PER_STREAM = 4;

  typedef enum logic [1:0] {
    MEM_CFG_REG_VADDR  = 2'd0,
    MEM_CFG_REG_SIZE   = 2'd1,
    MEM_CFG_REG_CTRL   = 2'd2,
    MEM_CFG_REG_STATUS = 2'd3
  } mem_cfg_reg_e;

  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_RECYCLE_BIT = 1;
  localparam int CTRL_CLR_ERR_BIT = 2;
  localparam int CTRL_ERR_RD_BIT  = 2;

  localparam int STAT_FULL_BIT   = 8;
  localparam int STAT_EMPTY_BIT  = 9;
  localparam int STAT_STAGED_BIT = 10;
  localparam int STAT_ERR_BIT    = 11;
endpackage

// File: rtl/mem_config_fifo.sv
// Show-ahead descriptor FIFO; pointers carry an extra wrap bit so full means exactly DEPTH.
module mem_config_fifo
  import libstf::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  buffer_t       push_data,
  input  logic          pop,
  input  logic          flush,
  output buffer_t       head,
  output logic [PW-1:0] occ,
  output logic          full,
  output logic          empty
);
  localparam int AW = PW - 1;

  buffer_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  assign occ   = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      // on full, a same-cycle pop frees the slot being written
      if (push && (!full || pop)) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_data;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop && !empty) rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/mem_config_queue.sv
// Per-stream descriptor queues fed from the host config bus: decode, staging, read mux, recycle.
module mem_config_queue
  import libstf::*;
#(
  parameter int NUM_STREAMS = 4,
  parameter int QUEUE_DEPTH = 4,
  parameter int VADDR_BITS  = VADDR_W,
  parameter int SIZE_BITS   = SIZE_W,
  parameter int ADDR_BITS   = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              conf_wr_valid,
  output logic                              conf_wr_ready,
  input  logic [ADDR_BITS-1:0]              conf_wr_addr,
  input  logic [63:0]                       conf_wr_data,
  input  logic                              conf_rd_valid,
  input  logic [ADDR_BITS-1:0]              conf_rd_addr,
  output logic [63:0]                       conf_rd_data,
  output logic                              conf_rd_resp,
  output logic [NUM_STREAMS-1:0]            out_valid,
  input  logic [NUM_STREAMS-1:0]            out_ready,
  output logic [NUM_STREAMS*VADDR_BITS-1:0] out_vaddr,
  output logic [NUM_STREAMS*SIZE_BITS-1:0]  out_size
);
  localparam int PW       = $clog2(QUEUE_DEPTH) + 1;
  localparam int SW       = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam int MAP_REGS = NUM_STREAMS * MEM_CFG_REGS_PER_STREAM;

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_i_n;

  logic [NUM_STREAMS-1:0] staged_q, staged_d, err_q, err_d, rec_q, rec_d, flush_q, flush_d;
  logic [NUM_STREAMS-1:0][VADDR_BITS-1:0] stage_q, stage_d;
  logic [NUM_STREAMS-1:0] push, pop, rec_push, stall, full, empty;
  logic [NUM_STREAMS-1:0][PW-1:0] occ;
  buffer_t [NUM_STREAMS-1:0] push_data, head;

  logic          wr_in_map, rd_in_map, wr_fire;
  logic [SW-1:0] wr_sid, rd_sid;
  logic [1:0]    wr_reg, rd_reg;
  logic [63:0]   rd_data_q, rd_data_d;
  logic          rd_resp_q;

  // async assert, sync deassert
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end
  assign rst_i_n = rst_sync_q[1];

  assign wr_in_map = conf_wr_addr < ADDR_BITS'(MAP_REGS);
  assign rd_in_map = conf_rd_addr < ADDR_BITS'(MAP_REGS);
  assign wr_sid    = conf_wr_addr[SW+1:2];
  assign rd_sid    = conf_rd_addr[SW+1:2];
  assign wr_reg    = conf_wr_addr[1:0];
  assign rd_reg    = conf_rd_addr[1:0];

  // the FIFO has one write port, so a recycle re-push holds off the host commit
  always_comb begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      pop[i]      = ~empty[i] & out_ready[i];
      rec_push[i] = pop[i] & rec_q[i];
      stall[i]    = conf_wr_valid & wr_in_map & (wr_sid == SW'(i)) &
                    (wr_reg == MEM_CFG_REG_SIZE) & staged_q[i] & ~flush_q[i] &
                    (rec_push[i] | (full[i] & ~pop[i]));
    end
  end

  assign conf_wr_ready = rst_i_n & ~|stall;
  assign wr_fire       = conf_wr_valid & conf_wr_ready;

  always_comb begin
    staged_d  = staged_q;
    stage_d   = stage_q;
    err_d     = err_q;
    rec_d     = rec_q;
    flush_d   = '0;
    push      = '0;
    push_data = head;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (wr_fire && wr_in_map && (wr_sid == SW'(i))) begin
        case (wr_reg)
          MEM_CFG_REG_VADDR: begin
            stage_d[i]  = conf_wr_data[VADDR_BITS-1:0];
            staged_d[i] = 1'b1;
          end
          MEM_CFG_REG_SIZE: begin
            if (!flush_q[i]) begin
              if (staged_q[i]) begin
                push[i]            = 1'b1;
                push_data[i].vaddr = vaddress_t'(stage_q[i]);
                push_data[i].size  = alloc_size_t'(conf_wr_data[SIZE_BITS-1:0]);
                staged_d[i]        = 1'b0;
              end else begin
                err_d[i] = 1'b1;
              end
            end
          end
          MEM_CFG_REG_CTRL: begin
            flush_d[i] = conf_wr_data[CTRL_FLUSH_BIT];
            rec_d[i]   = conf_wr_data[CTRL_RECYCLE_BIT];
            if (conf_wr_data[CTRL_CLR_ERR_BIT]) err_d[i] = 1'b0;
          end
          default: ;
        endcase
      end
      if (rec_push[i]) begin
        push[i]      = 1'b1;
        push_data[i] = head[i];
      end
      if (flush_q[i]) staged_d[i] = 1'b0;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (conf_rd_valid) begin
      rd_data_d = '0;
      if (rd_in_map) begin
        case (rd_reg)
          MEM_CFG_REG_CTRL: begin
            rd_data_d[CTRL_RECYCLE_BIT] = rec_q[rd_sid];
            rd_data_d[CTRL_ERR_RD_BIT]  = err_q[rd_sid];
          end
          MEM_CFG_REG_STATUS: begin
            rd_data_d[PW-1:0]           = occ[rd_sid];
            rd_data_d[STAT_FULL_BIT]    = full[rd_sid];
            rd_data_d[STAT_EMPTY_BIT]   = empty[rd_sid];
            rd_data_d[STAT_STAGED_BIT]  = staged_q[rd_sid];
            rd_data_d[STAT_ERR_BIT]     = err_q[rd_sid];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      staged_q  <= '0;
      stage_q   <= '0;
      err_q     <= '0;
      rec_q     <= '0;
      flush_q   <= '0;
      rd_data_q <= '0;
      rd_resp_q <= 1'b0;
    end else begin
      staged_q  <= staged_d;
      stage_q   <= stage_d;
      err_q     <= err_d;
      rec_q     <= rec_d;
      flush_q   <= flush_d;
      rd_data_q <= rd_data_d;
      rd_resp_q <= conf_rd_valid;
    end
  end

  assign conf_rd_data = rd_data_q;
  assign conf_rd_resp = rd_resp_q;
  assign out_valid    = ~empty;

  for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_strm
    mem_config_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_i_n),
      .push      (push[i]),
      .push_data (push_data[i]),
      .pop       (pop[i]),
      .flush     (flush_q[i]),
      .head      (head[i]),
      .occ       (occ[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
    assign out_vaddr[i*VADDR_BITS +: VADDR_BITS] = head[i].vaddr;
    assign out_size[i*SIZE_BITS +: SIZE_BITS]    = head[i].size;
  end
endmodule

// File: tb/tb_mem_config_queue.sv
// Bench for mem_config_queue: directed scenarios plus random traffic against a queue-based model.
module tb_mem_config_queue;
  localparam int NS = 4, D = 4, VB = 64, SB = 32, AB = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              conf_wr_valid = 1'b0;
  logic              conf_wr_ready;
  logic [AB-1:0]     conf_wr_addr = '0;
  logic [63:0]       conf_wr_data = '0;
  logic              conf_rd_valid = 1'b0;
  logic [AB-1:0]     conf_rd_addr = '0;
  logic [63:0]       conf_rd_data;
  logic              conf_rd_resp;
  logic [NS-1:0]     out_valid;
  logic [NS-1:0]     out_ready = '0;
  logic [NS*VB-1:0]  out_vaddr;
  logic [NS*SB-1:0]  out_size;

  always #5 clk = ~clk;

  mem_config_queue #(.NUM_STREAMS(NS), .QUEUE_DEPTH(D), .VADDR_BITS(VB),
                     .SIZE_BITS(SB), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n),
    .conf_wr_valid(conf_wr_valid), .conf_wr_ready(conf_wr_ready),
    .conf_wr_addr(conf_wr_addr), .conf_wr_data(conf_wr_data),
    .conf_rd_valid(conf_rd_valid), .conf_rd_addr(conf_rd_addr),
    .conf_rd_data(conf_rd_data), .conf_rd_resp(conf_rd_resp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vaddr(out_vaddr), .out_size(out_size)
  );

  int errors = 0, checks = 0;

  // reference model: one queue of {vaddr,size} per stream
  logic [95:0]   mq [NS][$];
  logic [NS-1:0] m_staged, m_err, m_rec, m_flush;
  logic [63:0]   m_stage [NS];
  logic          m_rd_pend;
  logic [63:0]   m_rd_exp;
  bit            last_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      mq[s].delete();
      m_stage[s] = '0;
    end
    m_staged = '0; m_err = '0; m_rec = '0; m_flush = '0; m_rd_pend = 1'b0; m_rd_exp = '0;
  endtask

  function automatic logic [63:0] m_read(input logic [AB-1:0] a);
    logic [63:0] v;
    int s, r;
    v = '0;
    if (int'(a) < NS*4) begin
      s = int'(a) / 4;
      r = int'(a) % 4;
      if (r == 2) begin
        v[1] = m_rec[s];
        v[2] = m_err[s];
      end else if (r == 3) begin
        v[7:0] = 8'(mq[s].size());
        v[8]   = (mq[s].size() == D);
        v[9]   = (mq[s].size() == 0);
        v[10]  = m_staged[s];
        v[11]  = m_err[s];
      end
    end
    return v;
  endfunction

  // one clock: check outputs at negedge against the model, then advance the model
  task automatic step();
    logic [NS-1:0] pops, exp_valid, new_flush;
    logic [95:0]   h;
    bit            exp_rdy;
    int            s, r;
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      pops[i]      = (mq[i].size() > 0) && out_ready[i];
      exp_valid[i] = (mq[i].size() > 0);
    end
    chk("out_valid", out_valid, exp_valid);
    for (int i = 0; i < NS; i++)
      if (mq[i].size() > 0) begin
        chk($sformatf("head_vaddr%0d", i), out_vaddr[i*VB +: VB], mq[i][0][95:32]);
        chk($sformatf("head_size%0d", i), out_size[i*SB +: SB], mq[i][0][31:0]);
      end
    s = int'(conf_wr_addr) / 4;
    r = int'(conf_wr_addr) % 4;
    exp_rdy = 1'b1;
    if (conf_wr_valid && s < NS && r == 1 && m_staged[s] && !m_flush[s] &&
        ((pops[s] && m_rec[s]) || (mq[s].size() == D && !pops[s])))
      exp_rdy = 1'b0;
    chk("wr_ready", conf_wr_ready, exp_rdy);
    chk("rd_resp", conf_rd_resp, m_rd_pend);
    if (m_rd_pend) chk("rd_data", conf_rd_data, m_rd_exp);
    m_rd_pend = conf_rd_valid;
    if (conf_rd_valid) m_rd_exp = m_read(conf_rd_addr);

    for (int i = 0; i < NS; i++) begin
      if (m_flush[i]) mq[i].delete();
      else if (pops[i]) begin
        h = mq[i].pop_front();
        if (m_rec[i]) mq[i].push_back(h);
      end
    end
    last_acc  = conf_wr_valid && exp_rdy;
    new_flush = '0;
    if (last_acc && s < NS) begin
      case (r)
        0: begin m_stage[s] = conf_wr_data; m_staged[s] = 1'b1; end
        1: if (!m_flush[s]) begin
             if (m_staged[s]) begin
               mq[s].push_back({m_stage[s], conf_wr_data[31:0]});
               m_staged[s] = 1'b0;
             end else m_err[s] = 1'b1;
           end
        2: begin
             m_rec[s] = conf_wr_data[1];
             if (conf_wr_data[2]) m_err[s] = 1'b0;
             new_flush[s] = conf_wr_data[0];
           end
        default: ;
      endcase
    end
    m_staged = m_staged & ~m_flush;
    m_flush  = new_flush;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AB-1:0] a, input logic [63:0] d);
    conf_wr_valid = 1'b1; conf_wr_addr = a; conf_wr_data = d;
    for (int k = 0; k < 16; k++) begin
      step();
      if (last_acc) break;
    end
    if (!last_acc) chk("wr_timeout", conf_wr_ready, 1);
    conf_wr_valid = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [AB-1:0] a, input logic [63:0] e);
    conf_rd_valid = 1'b1; conf_rd_addr = a;
    step();
    conf_rd_valid = 1'b0;
    chk(tag, conf_rd_data, e);
  endtask

  task automatic do_reset_release();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
  endtask

  logic [63:0] seq [6];
  logic [AB-1:0] ra;

  initial begin
    model_reset();
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wr_ready", conf_wr_ready, 0);
    chk("rst_rd_resp", conf_rd_resp, 0);
    chk("rst_rd_data", conf_rd_data, 0);
    chk("rst_vaddr_known", $isunknown(out_vaddr), 0);
    do_reset_release();
    chk("post_rst_wr_ready", conf_wr_ready, 1);

    // single commit on stream 1
    wr(8'd4, 64'h1000);
    wr(8'd5, 64'h40);
    chk("s1_valid", out_valid, 4'b0010);
    chk("s1_vaddr", out_vaddr[1*VB +: VB], 64'h1000);
    chk("s1_size", out_size[1*SB +: SB], 64'h40);
    out_ready[1] = 1'b1; step(); out_ready[1] = 1'b0;

    // fill stream 0, fifth commit stalls until a pop
    for (int k = 0; k < 4; k++) begin
      wr(8'd0, 64'hA000 + 64'(k) * 64'h100);
      wr(8'd1, 64'(k + 1));
    end
    wr(8'd0, 64'hA400);
    conf_wr_valid = 1'b1; conf_wr_addr = 8'd1; conf_wr_data = 64'd5;
    step(); step();
    rd_chk("s0_full_status", 8'd3, 64'h504);
    chk("s0_stall_ready", conf_wr_ready, 0);
    out_ready[0] = 1'b1; step();
    out_ready[0] = 1'b0; conf_wr_valid = 1'b0;
    rd_chk("s0_after_pop", 8'd3, 64'h104);
    chk("s0_new_head", out_vaddr[0 +: VB], 64'hA100);
    wr(8'd2, 64'h1); step();
    rd_chk("s0_flushed", 8'd3, 64'h200);

    // SIZE without VADDR on stream 2
    wr(8'd9, 64'h77);
    chk("s2_no_push", out_valid[2], 0);
    rd_chk("s2_err_status", 8'd11, 64'hA00);
    rd_chk("s2_err_ctrl", 8'd10, 64'h4);
    wr(8'd10, 64'h4);
    rd_chk("s2_err_cleared", 8'd11, 64'h200);

    // recycle ring on stream 3
    wr(8'd14, 64'h2);
    rd_chk("s3_ctrl_rec", 8'd14, 64'h2);
    seq = '{64'h3000, 64'h3100, 64'h3200, 64'h3000, 64'h3100, 64'h3200};
    for (int k = 0; k < 3; k++) begin
      wr(8'd12, seq[k]);
      wr(8'd13, 64'(k + 16));
    end
    out_ready[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rec_head%0d", k), out_vaddr[3*VB +: VB], seq[k]);
      step();
    end
    out_ready[3] = 1'b0;
    rd_chk("rec_occ", 8'd15, 64'h3);
    wr(8'd14, 64'h0);

    // flush while full, with a concurrent pop and SIZE write
    wr(8'd12, 64'h3300); wr(8'd13, 64'h10);
    rd_chk("s3_full", 8'd15, 64'h104);
    wr(8'd12, 64'h3400);
    wr(8'd14, 64'h1);
    conf_wr_valid = 1'b1; conf_wr_addr = 8'd13; conf_wr_data = 64'h20; out_ready[3] = 1'b1;
    step();
    conf_wr_valid = 1'b0; out_ready[3] = 1'b0;
    chk("flush_valid", out_valid[3], 0);
    rd_chk("flush_status", 8'd15, 64'h200);

    // out-of-map access
    wr(8'd17, 64'hFFFF);
    rd_chk("oom_read", 8'd16, 64'h0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      if (!conf_wr_valid && $urandom_range(0, 2) == 0) begin
        ra = AB'($urandom_range(0, 17));
        conf_wr_valid = 1'b1;
        conf_wr_addr  = ra;
        if (ra[1:0] == 2'd2)
          conf_wr_data = ($urandom_range(0, 7) == 0) ? 64'h1 : 64'($urandom_range(0, 7) & 6);
        else
          conf_wr_data = {$urandom, $urandom};
      end
      conf_rd_valid = ($urandom_range(0, 3) == 0);
      conf_rd_addr  = AB'($urandom_range(0, 17));
      out_ready     = NS'($urandom);
      step();
      if (last_acc) conf_wr_valid = 1'b0;
    end
    conf_wr_valid = 1'b0; conf_rd_valid = 1'b0; out_ready = '0;
    step();

    // reset in the middle of traffic
    wr(8'd2, 64'h1); step();
    wr(8'd0, 64'h5000); wr(8'd1, 64'h10);
    wr(8'd0, 64'h5100); wr(8'd1, 64'h20);
    out_ready[0] = 1'b1; step();
    chk("pre_rst_valid", out_valid[0], 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", conf_wr_ready, 0);
    out_ready = '0;
    do_reset_release();
    chk("post_rst2_ready", conf_wr_ready, 1);
    rd_chk("post_rst_status0", 8'd3, 64'h200);
    rd_chk("post_rst_ctrl0", 8'd2, 64'h0);
    rd_chk("post_rst_status3", 8'd15, 64'h200);
    rd_chk("post_rst_ctrl3", 8'd14, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
